// File: rtl/radiant_trig_pkg.sv
// radiant_trig_pkg
//   Shared constants, FSM state type and window helper for the RADIANT L0
//   coincidence trigger.
//   NCHAN_DEF   : default number of trigger channels
//   WIN_FIELD_W : width of each of the three packed window fields
//   WIN_W       : width of the summed window length / stretch counter
//   CNT_W       : width of the popcount and threshold
package radiant_trig_pkg;

  localparam int NCHAN_DEF   = 24;
  localparam int WIN_FIELD_W = 5;
  localparam int WIN_W       = 7;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // The window word carries three 5-bit fields; the stretch length is their
  // sum, which tops out at 93 and so fits in 7 bits without wrapping.
  function automatic logic [WIN_W-1:0] window_len(
    input logic [3*WIN_FIELD_W-1:0] win
  );
    window_len = WIN_W'(win[3*WIN_FIELD_W-1:2*WIN_FIELD_W])
               + WIN_W'(win[2*WIN_FIELD_W-1:WIN_FIELD_W])
               + WIN_W'(win[WIN_FIELD_W-1:0]);
  endfunction

endpackage

// File: rtl/radiant_trig_stretch.sv
// radiant_trig_stretch
//   Single-channel edge detector and coincidence-window stretcher.
//   clk, rst_b : system clock, asynchronous active-low reset
//   trig       : synchronized comparator level
//   mask       : 1 = channel may start a new stretch
//   en         : global enable; 0 clears the stretch
//   win_len    : reload value W; channel stays active W+1 cycles
//   active     : registered stretch output
module radiant_trig_stretch
  import radiant_trig_pkg::*;
(
  input  logic             clk,
  input  logic             rst_b,
  input  logic             trig,
  input  logic             mask,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  output logic             active
);

  logic             trig_q;
  logic [WIN_W-1:0] cnt_q;
  logic             rise;

  // The mask only gates new edges, so dropping it mid-window lets the
  // running stretch finish.
  assign rise = trig & ~trig_q & mask & en;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
      active <= 1'b0;
    end else begin
      trig_q <= trig;
      if (!en) begin
        cnt_q  <= '0;
        active <= 1'b0;
      end else if (rise) begin
        cnt_q  <= win_len;
        active <= 1'b1;
      end else begin
        // active follows the pre-decrement count, giving W+1 active cycles
        active <= (cnt_q != '0);
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/radiant_trig_coinc.sv
// radiant_trig_coinc
//   Per-channel coincidence trigger: stretches each enabled channel's rising
//   edge into a window, counts overlapping channels and fires a one-cycle
//   trigger when the count exceeds the threshold.
//   clk, rst_b   : system clock, asynchronous active-low reset
//   trig_i       : synchronized comparator outputs (level)
//   en_i         : global enable; 0 forces IDLE and clears all stretches
//   chan_mask_i  : 1 = channel participates
//   window_i     : packed window {A, B, C}; W = A + B + C
//   thresh_i     : fire when overlapping channels > thresh_i
//   trig_o       : single-cycle trigger pulse
//   trig_chans_o : active-channel snapshot at the fire cycle, held until next
//   busy_o       : high while in HOLDOFF
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | disabled; no triggers, stretches held clear
//   ARMED   | watching the popcount; fires when it exceeds thresh_i
//   HOLDOFF | fired; waits until every channel's stretch has expired
module radiant_trig_coinc
  import radiant_trig_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NCHAN-1:0]         trig_i,
  input  logic                     en_i,
  input  logic [NCHAN-1:0]         chan_mask_i,
  input  logic [3*WIN_FIELD_W-1:0] window_i,
  input  logic [CNT_W-1:0]         thresh_i,
  output logic                     trig_o,
  output logic [NCHAN-1:0]         trig_chans_o,
  output logic                     busy_o
);

  logic [WIN_W-1:0] win_len;
  logic [NCHAN-1:0] active;
  logic [NCHAN-1:0] active_d;
  logic [CNT_W-1:0] pop_next;
  logic [CNT_W-1:0] pop_q;
  state_t           state_q;
  state_t           state_d;
  logic             fire;

  assign win_len = window_len(window_i);

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    radiant_trig_stretch u_stretch (
      .clk     (clk),
      .rst_b   (rst_b),
      .trig    (trig_i[g]),
      .mask    (chan_mask_i[g]),
      .en      (en_i),
      .win_len (win_len),
      .active  (active[g])
    );
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < NCHAN; i++) begin
      pop_next = pop_next + CNT_W'(active[i]);
    end
  end

  // active_d is the vector pop_q was counted from, so the snapshot taken on
  // a fire matches the channels that caused it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pop_q    <= '0;
      active_d <= '0;
    end else begin
      pop_q    <= pop_next;
      active_d <= active;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (pop_q > thresh_i) begin
          fire    = 1'b1;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        // leave only once the live stretches have all expired
        if (active == '0) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!en_i) begin
      state_d = IDLE;
      fire    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      trig_o       <= 1'b0;
      trig_chans_o <= '0;
    end else begin
      trig_o <= fire;
      if (fire) begin
        trig_chans_o <= active_d;
      end
    end
  end

  assign busy_o = (state_q == HOLDOFF);

endmodule

// File: tb/tb_radiant_trig_coinc.sv
// tb_radiant_trig_coinc
//   Directed bench for radiant_trig_coinc. Inputs change 1 time unit after
//   the rising edge, outputs are read at the same point. A pulse driven in
//   cycle N is the edge cycle; trig_o follows at N+3.
module tb_radiant_trig_coinc;

  localparam int N = 24;
  localparam logic [14:0] WIN73 = {5'd11, 5'd31, 5'd31};
  localparam logic [14:0] WIN0  = 15'd0;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [N-1:0]  trig_i;
  logic          en_i;
  logic [N-1:0]  chan_mask_i;
  logic [14:0]   window_i;
  logic [4:0]    thresh_i;
  logic          trig_o;
  logic [N-1:0]  trig_chans_o;
  logic          busy_o;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int fires   = 0;

  radiant_trig_coinc dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .trig_i       (trig_i),
    .en_i         (en_i),
    .chan_mask_i  (chan_mask_i),
    .window_i     (window_i),
    .thresh_i     (thresh_i),
    .trig_o       (trig_o),
    .trig_chans_o (trig_chans_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (trig_o === 1'b1) fires++;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse(input logic [N-1:0] chans);
    trig_i = chans;
    step();
    trig_i = '0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; en_i = 1'b0; trig_i = '0;
    chan_mask_i = '1; window_i = WIN73; thresh_i = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL reset_trig_o got %b exp 0", trig_o); end
    vectors++; if (trig_chans_o !== '0) begin errors++; $display("FAIL reset_chans got %h exp 000000", trig_chans_o); end
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    rst_b = 1'b1;
    en_i  = 1'b1;
    repeat (4) step();
    vectors++; if (fires !== 0) begin errors++; $display("FAIL reset_no_fire got %0d exp 0", fires); end
  endtask

  task automatic test_coincidence();
    int c, f0;
    c = cyc; f0 = fires;
    pulse(24'h000001);
    run_to(c + 10); pulse(24'h000002);
    run_to(c + 20); pulse(24'h000004);
    run_to(c + 22);
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL coinc_early got %b exp 0", trig_o); end
    step();
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL coinc_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'h000007) begin errors++; $display("FAIL coinc_chans got %h exp 000007", trig_chans_o); end
    vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL coinc_busy got %b exp 1", busy_o); end
    step();
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL coinc_one_cycle got %b exp 0", trig_o); end
    // last stretch (ch2) is active c+21..c+94
    run_to(c + 95);
    vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL coinc_busy_hold got %b exp 1", busy_o); end
    step();
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL coinc_busy_exit got %b exp 0", busy_o); end
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL coinc_count got %0d exp 1", fires - f0); end
    run_to(c + 110);
  endtask

  // ch0 active c+1..c+74: ch2 at +73 overlaps it for one cycle, at +74 not.
  task automatic test_window_boundary();
    int c, f0;
    c = cyc; f0 = fires;
    pulse(24'h000001);
    run_to(c + 10); pulse(24'h000002);
    run_to(c + 73); pulse(24'h000004);
    run_to(c + 76);
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL edge73_fire got %b exp 1", trig_o); end
    run_to(c + 200);
    c = cyc; f0 = fires;
    pulse(24'h000001);
    run_to(c + 10); pulse(24'h000002);
    run_to(c + 74); pulse(24'h000004);
    run_to(c + 90);
    vectors++; if (fires - f0 !== 0) begin errors++; $display("FAIL edge74_nofire got %0d exp 0", fires - f0); end
    run_to(c + 120); pulse(24'h000004);
    run_to(c + 130);
    vectors++; if (fires - f0 !== 0) begin errors++; $display("FAIL edge80_nofire got %0d exp 0", fires - f0); end
    run_to(c + 220);
  endtask

  task automatic test_single_thresh0();
    int c, f0;
    thresh_i = 5'd0; window_i = WIN0; chan_mask_i = 24'h000001;
    step();
    c = cyc; f0 = fires;
    pulse(24'h000001);
    run_to(c + 2);
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL t0_early got %b exp 0", trig_o); end
    step();
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL t0_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'h000001) begin errors++; $display("FAIL t0_chans got %h exp 000001", trig_chans_o); end
    vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t0_busy got %b exp 1", busy_o); end
    step();
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t0_w0_exit got %b exp 0", busy_o); end
    run_to(c + 10); pulse(24'h000002);
    run_to(c + 20);
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL t0_mask got %0d exp 1", fires - f0); end
  endtask

  task automatic test_holdoff();
    int c, f0;
    thresh_i = 5'd2; window_i = WIN73; chan_mask_i = '1;
    step();
    c = cyc; f0 = fires;
    pulse(24'h000007);
    run_to(c + 3);
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL ho_simul_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'h000007) begin errors++; $display("FAIL ho_chans1 got %h exp 000007", trig_chans_o); end
    run_to(c + 10); pulse(24'h0000F8);
    run_to(c + 85);
    vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ho_busy_hold got %b exp 1", busy_o); end
    step();
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ho_busy_exit got %b exp 0", busy_o); end
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL ho_no_refire got %0d exp 1", fires - f0); end
    run_to(c + 100); pulse(24'h000700);
    run_to(c + 103);
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL ho_rearm_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'h000700) begin errors++; $display("FAIL ho_chans2 got %h exp 000700", trig_chans_o); end
    run_to(c + 200);
  endtask

  task automatic test_retrigger();
    int c, f0, low;
    thresh_i = 5'd0; chan_mask_i = 24'h000001;
    step();
    c = cyc; f0 = fires; low = 0;
    pulse(24'h000001);
    run_to(c + 3);
    while (cyc < c + 225) begin
      if (cyc == c + 50 || cyc == c + 100 || cyc == c + 150) begin
        pulse(24'h000001);
      end else begin
        step();
      end
      if (busy_o !== 1'b1) low++;
    end
    vectors++; if (low !== 0) begin errors++; $display("FAIL retrig_busy_low got %0d exp 0", low); end
    step();
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL retrig_exit got %b exp 0", busy_o); end
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL retrig_count got %0d exp 1", fires - f0); end
    run_to(c + 240);
  endtask

  task automatic test_enable_clear();
    int c, f0;
    thresh_i = 5'd2; chan_mask_i = '1;
    step();
    c = cyc; f0 = fires;
    pulse(24'h000070);
    run_to(c + 3);
    vectors++; if (trig_chans_o !== 24'h000070) begin errors++; $display("FAIL en_chans got %h exp 000070", trig_chans_o); end
    run_to(c + 10);
    en_i = 1'b0;
    step();
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL en_idle got %b exp 0", busy_o); end
    vectors++; if (trig_chans_o !== 24'h000070) begin errors++; $display("FAIL en_chans_hold got %h exp 000070", trig_chans_o); end
    run_to(c + 13);
    en_i = 1'b1;
    step();
    pulse(24'h000180);
    run_to(c + 30);
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL en_cleared got %0d exp 1", fires - f0); end
    run_to(c + 120);
  endtask

  task automatic test_thresh_max();
    int c, f0;
    thresh_i = 5'd24; chan_mask_i = '1;
    step();
    c = cyc; f0 = fires;
    pulse('1);
    run_to(c + 8);
    vectors++; if (fires - f0 !== 0) begin errors++; $display("FAIL tmax_nofire got %0d exp 0", fires - f0); end
    thresh_i = 5'd23;
    step();
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL t23_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'hFFFFFF) begin errors++; $display("FAIL t23_chans got %h exp ffffff", trig_chans_o); end
    thresh_i = 5'd2;
    run_to(c + 100);
  endtask

  task automatic test_async_reset();
    int c, x, f0;
    c = cyc;
    pulse(24'h000007);
    run_to(c + 4);
    vectors++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got %b exp 1", busy_o); end
    run_to(c + 10);
    #2;
    rst_b  = 1'b0;
    trig_i = 24'h000007;
    #1;
    vectors++; if (trig_chans_o !== '0) begin errors++; $display("FAIL ar_chans got %h exp 000000", trig_chans_o); end
    vectors++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ar_busy got %b exp 0", busy_o); end
    @(posedge clk);
    #3;
    cyc++;
    rst_b = 1'b1;
    x = cyc; f0 = fires;
    #1;
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL ar_release_glitch got %b exp 0", trig_o); end
    // inputs already high when reset lifts count as fresh edges
    run_to(x + 2);
    vectors++; if (trig_o !== 1'b0) begin errors++; $display("FAIL ar_early got %b exp 0", trig_o); end
    step();
    vectors++; if (trig_o !== 1'b1) begin errors++; $display("FAIL ar_edge_fire got %b exp 1", trig_o); end
    vectors++; if (trig_chans_o !== 24'h000007) begin errors++; $display("FAIL ar_edge_chans got %h exp 000007", trig_chans_o); end
    trig_i = '0;
    run_to(x + 20);
    vectors++; if (fires - f0 !== 1) begin errors++; $display("FAIL ar_count got %0d exp 1", fires - f0); end
  endtask

  initial begin
    test_reset();
    test_coincidence();
    test_window_boundary();
    test_single_thresh0();
    test_holdoff();
    test_retrigger();
    test_enable_clear();
    test_thresh_max();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
